bfly_fac8_1: RTL and testbench
==============================

Name: bfly_fac8_1

Overview:
- First radix-2 DIF butterfly stage of the 512-point FFT; sits directly upstream of the stage-1 twiddle multiplier.
- Accepts DEPTH=16 complex samples per cycle (<4.6>) and buffers the first half-frame (DELAY blocks).
- During the second half-frame, pairs each incoming block with its buffered partner and produces sum and difference lanes (<5.6>).
- Also generates the 2-bit twiddle `select` and the enable for the multiplier.

Parameters:
- IN_WIDTH, 10, input sample width, signed <4.6>
- WIDTH, 11, output width, signed <5.6> (= IN_WIDTH+1)
- DEPTH, 16, parallel lanes per block
- DELAY, 16, blocks per half-frame (butterfly stride 256 / DEPTH); power of two, >=4

Ports:
- clk, input, 1, clock
- rst_n, input, 1, asynchronous active-low reset
- din_valid, input, 1, one block of DEPTH samples present this cycle
- din_R[DEPTH-1:0], input, IN_WIDTH signed each, real lanes
- din_Q[DEPTH-1:0], input, IN_WIDTH signed each, imaginary lanes
- dout_R_add/dout_R_sub/dout_Q_add/dout_Q_sub[DEPTH-1:0], output, WIDTH signed each, butterfly results
- dout_valid, output, 1, outputs valid; drives multiplier en
- select, output, 2, twiddle group index for the multiplier
- frame_done, output, 1, one-cycle pulse with the last output block of a frame

Behaviour:
- Single clock domain. Reset is asynchronous, active-low. On reset: blk_cnt=0, dout_valid=0, select=0, frame_done=0, all dout lanes=0. Buffer RAM is not reset.
- blk_cnt (log2(2*DELAY) bits) advances only on cycles with din_valid=1. It wraps from 2*DELAY-1 to 0. Gaps in din_valid hold all state; outputs keep their last value and dout_valid drops to 0.
- FILL phase (blk_cnt < DELAY):
  - On din_valid, write din_R/din_Q of all lanes into buf[blk_cnt].
  - dout_valid=0 on the following cycle.
- BFLY phase (blk_cnt >= DELAY):
  - On din_valid, read buf[blk_cnt-DELAY]. Reads are combinational (register-array buffer).
  - Compute per lane: x_add = buf + din; x_sub = buf - din (buf minus din), for R and Q.
  - Sign-extend both operands to WIDTH before add/sub. No overflow is possible and no saturation is applied.
  - Register the results. dout_valid=1 exactly one cycle after the accepting edge (latency 1).
- select is registered with the data: select = (blk_cnt-DELAY) >> (log2(DELAY)-2). Each of the 4 twiddle groups spans DELAY/4 consecutive blocks, so select runs 0,0,0,0,1,...,3 for DELAY=16.
- frame_done=1 together with dout_valid for the block accepted at blk_cnt=2*DELAY-1; otherwise 0.
- Back-to-back frames: the first block of frame n+1 is accepted at the cycle after the wrap. It is written to buf[0] with no bubble, and dout_valid=0 for that cycle's output.
- Reset mid-frame: blk_cnt returns to 0. The next accepted block is treated as block 0 of a new frame; stale buffer contents are overwritten before use.
- Write and read never target the same buffer entry in one cycle, so no bypass is required.

Optional Feature:
- Macro BFLY_PIPE2_EN.
- When defined: an additional output register stage is inserted for timing. dout_*, dout_valid, select and frame_done are delayed together, giving latency 2. Reset clears both stages.
- When undefined: latency 1 as above. Port list is identical in both builds.

Test Plan:
- Reset then idle, din_valid=0 -> all outputs 0; dout_valid=0 indefinitely.
- Frame of 32 blocks: block k, lane j has din_R=k+j, din_Q=-(k+j) -> for k=16..31, dout_R_add=2k-16+2j, dout_R_sub=-16 (the buffered block is 16 lower than the current one), dout_Q_add=-(2k-16+2j), dout_Q_sub=+16. select sequence is 0x4,1x4,2x4,3x4; frame_done only on the 16th valid output.
- Extremes: buffered block -512 (0x200), current block -512 -> add=-1024 (0x400 in 11 bits), sub=0. Buffered 511, current -512 -> sub=1023, add=-1.
- din_valid toggling 1,0,1,0 across a whole frame -> identical dout sequence to the gapless run; dout_valid is high only one cycle after each accepted BFLY block.
- rst_n asserted asynchronously at blk_cnt=20, then a fresh frame -> no dout_valid until 16 new blocks are accepted; results use only the new frame's data.
- BFLY_PIPE2_EN build, rerun scenario 2 -> same values; dout_valid/select/frame_done shifted one extra cycle.

Source files
------------

// File: rtl/bfly_fac8_1.sv
// bfly_fac8_1: first radix-2 DIF butterfly stage of the 512-point FFT.
// The first half-frame is buffered. In the second half-frame each incoming block
// is paired with its buffered partner, producing sum and difference lanes plus
// the twiddle group select.
// Optional macro BFLY_PIPE2_EN adds a second output register stage (latency 2).
`timescale 1ns/1ps

module bfly_fac8_1 #(
    parameter int unsigned IN_WIDTH = 10,
    parameter int unsigned WIDTH    = 11,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned DELAY    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       din_valid,
    input  logic signed [IN_WIDTH-1:0] din_R      [DEPTH-1:0],
    input  logic signed [IN_WIDTH-1:0] din_Q      [DEPTH-1:0],
    output logic signed [WIDTH-1:0]    dout_R_add [DEPTH-1:0],
    output logic signed [WIDTH-1:0]    dout_R_sub [DEPTH-1:0],
    output logic signed [WIDTH-1:0]    dout_Q_add [DEPTH-1:0],
    output logic signed [WIDTH-1:0]    dout_Q_sub [DEPTH-1:0],
    output logic                       dout_valid,
    output logic [1:0]                 select,
    output logic                       frame_done
);

    localparam int unsigned IDX_W = $clog2(DELAY);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned SHIFT = IDX_W - 2;
    localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(2 * DELAY - 1);

    typedef logic signed [WIDTH-1:0] lane_t;

    // Half-frame buffer, register array so reads are combinational.
    logic signed [IN_WIDTH-1:0] mem_r_q [DELAY-1:0][DEPTH-1:0];
    logic signed [IN_WIDTH-1:0] mem_q_q [DELAY-1:0][DEPTH-1:0];

    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
    lane_t            r_add_q [DEPTH-1:0];
    lane_t            r_add_d [DEPTH-1:0];
    lane_t            r_sub_q [DEPTH-1:0];
    lane_t            r_sub_d [DEPTH-1:0];
    lane_t            q_add_q [DEPTH-1:0];
    lane_t            q_add_d [DEPTH-1:0];
    lane_t            q_sub_q [DEPTH-1:0];
    lane_t            q_sub_d [DEPTH-1:0];
    logic             valid_q, valid_d;
    logic [1:0]       sel_q, sel_d;
    logic             done_q, done_d;

    // Upper counter half marks the butterfly phase; lower bits index the buffer.
    logic             bfly_phase_c;
    logic [IDX_W-1:0] idx_c;
    logic             acc_fill_c;
    logic             acc_bfly_c;

    assign bfly_phase_c = blk_cnt_q[CNT_W-1];
    assign idx_c        = blk_cnt_q[IDX_W-1:0];
    assign acc_fill_c   = din_valid & ~bfly_phase_c;
    assign acc_bfly_c   = din_valid &  bfly_phase_c;

    // Capture the first half-frame; buffer contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (acc_fill_c) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                mem_r_q[idx_c][j] <= din_R[j];
                mem_q_q[idx_c][j] <= din_Q[j];
            end
        end
    end

    // Next-state: block counter, butterfly results, select and frame marker.
    always_comb begin
        blk_cnt_d = blk_cnt_q;
        r_add_d   = r_add_q;
        r_sub_d   = r_sub_q;
        q_add_d   = q_add_q;
        q_sub_d   = q_sub_q;
        sel_d     = sel_q;
        valid_d   = acc_bfly_c;
        done_d    = acc_bfly_c && (blk_cnt_q == LAST_BLK);
        if (din_valid) begin
            blk_cnt_d = blk_cnt_q + CNT_W'(1);
        end
        if (acc_bfly_c) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                r_add_d[j] = WIDTH'(mem_r_q[idx_c][j]) + WIDTH'(din_R[j]);
                r_sub_d[j] = WIDTH'(mem_r_q[idx_c][j]) - WIDTH'(din_R[j]);
                q_add_d[j] = WIDTH'(mem_q_q[idx_c][j]) + WIDTH'(din_Q[j]);
                q_sub_d[j] = WIDTH'(mem_q_q[idx_c][j]) - WIDTH'(din_Q[j]);
            end
            sel_d = 2'(idx_c >> SHIFT);
        end
    end

    // First output stage and block counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q <= '0;
            r_add_q   <= '{default: '0};
            r_sub_q   <= '{default: '0};
            q_add_q   <= '{default: '0};
            q_sub_q   <= '{default: '0};
            valid_q   <= 1'b0;
            sel_q     <= 2'b00;
            done_q    <= 1'b0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
            r_add_q   <= r_add_d;
            r_sub_q   <= r_sub_d;
            q_add_q   <= q_add_d;
            q_sub_q   <= q_sub_d;
            valid_q   <= valid_d;
            sel_q     <= sel_d;
            done_q    <= done_d;
        end
    end

`ifdef BFLY_PIPE2_EN
    lane_t      r_add_p2_q [DEPTH-1:0];
    lane_t      r_sub_p2_q [DEPTH-1:0];
    lane_t      q_add_p2_q [DEPTH-1:0];
    lane_t      q_sub_p2_q [DEPTH-1:0];
    logic       valid_p2_q;
    logic [1:0] sel_p2_q;
    logic       done_p2_q;

    // Extra timing stage; everything moves together so alignment is preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_add_p2_q <= '{default: '0};
            r_sub_p2_q <= '{default: '0};
            q_add_p2_q <= '{default: '0};
            q_sub_p2_q <= '{default: '0};
            valid_p2_q <= 1'b0;
            sel_p2_q   <= 2'b00;
            done_p2_q  <= 1'b0;
        end else begin
            r_add_p2_q <= r_add_q;
            r_sub_p2_q <= r_sub_q;
            q_add_p2_q <= q_add_q;
            q_sub_p2_q <= q_sub_q;
            valid_p2_q <= valid_q;
            sel_p2_q   <= sel_q;
            done_p2_q  <= done_q;
        end
    end

    assign dout_R_add = r_add_p2_q;
    assign dout_R_sub = r_sub_p2_q;
    assign dout_Q_add = q_add_p2_q;
    assign dout_Q_sub = q_sub_p2_q;
    assign dout_valid = valid_p2_q;
    assign select     = sel_p2_q;
    assign frame_done = done_p2_q;
`else
    assign dout_R_add = r_add_q;
    assign dout_R_sub = r_sub_q;
    assign dout_Q_add = q_add_q;
    assign dout_Q_sub = q_sub_q;
    assign dout_valid = valid_q;
    assign select     = sel_q;
    assign frame_done = done_q;
`endif

endmodule

// File: tb/tb_bfly_fac8_1.sv
// Scoreboard bench for bfly_fac8_1: the driver pushes hand-derived expectations,
// and a monitor pops them and compares whenever dout_valid is presented.
`timescale 1ns/1ps

module tb_bfly_fac8_1;

    localparam int IN_W  = 10;
    localparam int W     = 11;
    localparam int DEPTH = 16;
`ifdef BFLY_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef logic [DEPTH-1:0][W-1:0] vec_t;
    typedef struct {
        vec_t       ra;
        vec_t       rs;
        vec_t       qa;
        vec_t       qs;
        logic [1:0] sel;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic din_valid;
    logic signed [IN_W-1:0] din_R [DEPTH-1:0];
    logic signed [IN_W-1:0] din_Q [DEPTH-1:0];
    logic signed [W-1:0] dout_R_add [DEPTH-1:0];
    logic signed [W-1:0] dout_R_sub [DEPTH-1:0];
    logic signed [W-1:0] dout_Q_add [DEPTH-1:0];
    logic signed [W-1:0] dout_Q_sub [DEPTH-1:0];
    logic dout_valid;
    logic [1:0] select;
    logic frame_done;

    exp_t exp_q [$];
    int n_cmp = 0;
    int n_err = 0;
    logic exp_bfly;
    logic [LAT-1:0] vpipe;

    bfly_fac8_1 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .din_R      (din_R),
        .din_Q      (din_Q),
        .dout_R_add (dout_R_add),
        .dout_R_sub (dout_R_sub),
        .dout_Q_add (dout_Q_add),
        .dout_Q_sub (dout_Q_sub),
        .dout_valid (dout_valid),
        .select     (select),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DEPTH*W-1:0] act, input logic [DEPTH*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t pack(input logic signed [W-1:0] a [DEPTH-1:0]);
        vec_t v;
        for (int j = 0; j < DEPTH; j++) v[j] = a[j];
        return v;
    endfunction

    // Expected dout_valid timing: one flag per accepted butterfly block.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) vpipe <= '0;
        else        vpipe <= LAT'({vpipe, exp_bfly});
    end

    // Monitor: check valid timing every cycle and pop the scoreboard on valid.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            chk("dout_valid", (DEPTH*W)'(dout_valid), (DEPTH*W)'(vpipe[LAT-1]));
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL scoreboard: got unexpected output expected none");
                end else begin
                    e = exp_q.pop_front();
                    chk("R_add", pack(dout_R_add), e.ra);
                    chk("R_sub", pack(dout_R_sub), e.rs);
                    chk("Q_add", pack(dout_Q_add), e.qa);
                    chk("Q_sub", pack(dout_Q_sub), e.qs);
                    chk("select", (DEPTH*W)'(select), (DEPTH*W)'(e.sel));
                    chk("frame_done", (DEPTH*W)'(frame_done), (DEPTH*W)'(e.fd));
                end
            end
        end
    end

    task automatic check_zero(input string name);
        chk({name, "_R_add"}, pack(dout_R_add), '0);
        chk({name, "_R_sub"}, pack(dout_R_sub), '0);
        chk({name, "_Q_add"}, pack(dout_Q_add), '0);
        chk({name, "_Q_sub"}, pack(dout_Q_sub), '0);
        chk({name, "_ctl"}, (DEPTH*W)'({dout_valid, select, frame_done}), '0);
    endtask

    // mode 0: lane value k+j+ofs (R) and its negative (Q); mode 1: range extremes.
    task automatic send(input int k, input int mode, input int ofs);
        exp_t e;
        for (int j = 0; j < DEPTH; j++) begin
            if (mode == 0) begin
                din_R[j] = IN_W'(k + j + ofs);
                din_Q[j] = IN_W'(-(k + j + ofs));
                e.ra[j]  = W'(2 * k - 16 + 2 * j + 2 * ofs);
                e.rs[j]  = W'(-16);
                e.qa[j]  = W'(-(2 * k - 16 + 2 * j + 2 * ofs));
                e.qs[j]  = W'(16);
            end else begin
                if (k < 16) begin
                    din_R[j] = (j % 2 == 0) ? IN_W'(-512) : IN_W'(511);
                    din_Q[j] = IN_W'(511);
                end else begin
                    din_R[j] = IN_W'(-512);
                    din_Q[j] = IN_W'(-512);
                end
                e.ra[j] = (j % 2 == 0) ? W'(-1024) : W'(-1);
                e.rs[j] = (j % 2 == 0) ? W'(0) : W'(1023);
                e.qa[j] = W'(-1);
                e.qs[j] = W'(1023);
            end
        end
        e.sel = (k >= 16) ? 2'((k - 16) / 4) : 2'b00;
        e.fd  = (k == 31);
        din_valid = 1'b1;
        exp_bfly  = (k >= 16);
        if (k >= 16) exp_q.push_back(e);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        exp_bfly  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        din_valid = 1'b0;
        exp_bfly  = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            din_R[j] = '0;
            din_Q[j] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        idle(8);
        check_zero("idle");

        // Gapless frame, then a back-to-back frame across the counter wrap.
        for (int k = 0; k < 32; k++) send(k, 0, 0);
        for (int k = 0; k < 32; k++) send(k, 0, 3);
        // din_valid toggling every cycle.
        for (int k = 0; k < 32; k++) begin
            send(k, 0, 5);
            idle(1);
        end
        // Input range extremes.
        for (int k = 0; k < 32; k++) send(k, 1, 0);
        idle(4);

        // Asynchronous reset with blk_cnt at 20, then a fresh frame.
        for (int k = 0; k < 20; k++) send(k, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        exp_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 32; k++) send(k, 0, 50);
        idle(LAT + 3);

        chk("drained", (DEPTH*W)'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
